// File: rtl/cn_iter_update_ctrl.sv
// Check-node IB-LUT iteration update: streams one iteration's page set from IB-ROM into the CN RAM banks.
// CN_WR_ROM_OREG_EN: ROM output register enabled (BRAM latency 2, write pipeline depth 3).

module cn_bank_latch #(
  parameter int W = 6
) (
  input  logic         write_clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge write_clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end
endmodule

module cn_iter_update_ctrl #(
  parameter int NUM_BANK     = 2,
  parameter int ROM_RD_BW    = 6,
  parameter int PAGE_NUM     = 32,
  parameter int PAGE_ADDR_BW = 5,
  parameter int ITER_NUM     = 25,
  parameter int ITER_ADDR_BW = 5,
  parameter int ROM_ADDR_BW  = ITER_ADDR_BW + PAGE_ADDR_BW
) (
  input  logic                          write_clk,
  input  logic                          rst,
  input  logic                          iter_rqst,
  input  logic                          iter_termination,
  input  logic [NUM_BANK*ROM_RD_BW-1:0] rom_rd_data,
  output logic                          rom_rd_en,
  output logic [ROM_ADDR_BW-1:0]        rom_rd_addr,
  output logic                          ram_wr_en,
  output logic [PAGE_ADDR_BW-1:0]       ram_wr_addr,
  output logic [NUM_BANK*ROM_RD_BW-1:0] ram_wr_data,
  output logic [ITER_ADDR_BW-1:0]       iter_idx,
  output logic                          last_iter,
  output logic                          busy,
  output logic                          update_done,
  output logic                          update_abort
);
`ifdef CN_WR_ROM_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  // read-to-write depth: BRAM latency plus the data-latch stage
  localparam int P      = LAT + 1;
  localparam int CNT_BW = $clog2(PAGE_NUM + 1);
  localparam int DRN_BW = $clog2(P + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

  state_t                         state, state_nxt;
  logic [CNT_BW-1:0]              page_cnt, page_cnt_nxt;
  logic [DRN_BW-1:0]              drn_cnt, drn_cnt_nxt;
  logic [ITER_ADDR_BW-1:0]        iter_nxt;
  logic [PAGE_ADDR_BW-1:0]        rd_page_nxt;
  logic                           rd_en_nxt, done_nxt, abort_nxt, squash;
  logic [LAT:1]                   vld_pipe;
  logic [LAT:1][PAGE_ADDR_BW-1:0] pg_pipe;

  always_comb begin
    state_nxt    = state;
    page_cnt_nxt = page_cnt;
    drn_cnt_nxt  = drn_cnt;
    iter_nxt     = iter_idx;
    rd_page_nxt  = '0;
    rd_en_nxt    = 1'b0;
    done_nxt     = 1'b0;
    abort_nxt    = 1'b0;
    squash       = 1'b0;
    case (state)
      IDLE: begin
        if (iter_termination) begin
          iter_nxt = '0;
        end else if (iter_rqst) begin
          state_nxt    = FETCH;
          rd_en_nxt    = 1'b1;
          rd_page_nxt  = '0;
          page_cnt_nxt = CNT_BW'(1);
        end
      end
      FETCH: begin
        if (iter_termination) begin
          squash    = 1'b1;
          abort_nxt = 1'b1;
          iter_nxt  = '0;
          state_nxt = FINISH;
        end else if (page_cnt == CNT_BW'(PAGE_NUM)) begin
          state_nxt   = DRAIN;
          drn_cnt_nxt = '0;
        end else begin
          rd_en_nxt    = 1'b1;
          rd_page_nxt  = PAGE_ADDR_BW'(page_cnt);
          page_cnt_nxt = page_cnt + CNT_BW'(1);
        end
      end
      DRAIN: begin
        if (iter_termination) begin
          squash    = 1'b1;
          abort_nxt = 1'b1;
          iter_nxt  = '0;
          state_nxt = FINISH;
        end else if (drn_cnt == DRN_BW'(P - 1)) begin
          done_nxt  = 1'b1;
          state_nxt = FINISH;
        end else begin
          drn_cnt_nxt = drn_cnt + DRN_BW'(1);
        end
      end
      FINISH: begin
        state_nxt = IDLE;
        // a late termination turns a completed update into an abort
        if (iter_termination) begin
          iter_nxt  = '0;
          abort_nxt = update_done;
        end else if (update_done) begin
          iter_nxt = (iter_idx == ITER_ADDR_BW'(ITER_NUM - 1)) ? '0 : iter_idx + ITER_ADDR_BW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      page_cnt     <= '0;
      drn_cnt      <= '0;
      iter_idx     <= '0;
      last_iter    <= 1'b0;
      busy         <= 1'b0;
      update_done  <= 1'b0;
      update_abort <= 1'b0;
      rom_rd_en    <= 1'b0;
      rom_rd_addr  <= '0;
    end else begin
      state        <= state_nxt;
      page_cnt     <= page_cnt_nxt;
      drn_cnt      <= drn_cnt_nxt;
      iter_idx     <= iter_nxt;
      last_iter    <= (iter_nxt == ITER_ADDR_BW'(ITER_NUM - 1));
      busy         <= (state_nxt != IDLE);
      update_done  <= done_nxt;
      update_abort <= abort_nxt;
      rom_rd_en    <= rd_en_nxt;
      if (rd_en_nxt) rom_rd_addr <= {iter_idx, rd_page_nxt};
    end
  end

  // write pipeline: valid/page ride alongside the ROM latency
  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) begin
      vld_pipe    <= '0;
      pg_pipe     <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
    end else begin
      vld_pipe[1] <= rom_rd_en & ~squash;
      pg_pipe[1]  <= rom_rd_addr[PAGE_ADDR_BW-1:0];
      for (int i = 2; i <= LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1] & ~squash;
        pg_pipe[i]  <= pg_pipe[i-1];
      end
      ram_wr_en <= vld_pipe[LAT] & ~squash;
      if (vld_pipe[LAT]) ram_wr_addr <= pg_pipe[LAT];
    end
  end

  for (genvar k = 0; k < NUM_BANK; k++) begin : g_bank
    cn_bank_latch #(.W(ROM_RD_BW)) u_latch (
      .write_clk (write_clk),
      .rst       (rst),
      .en        (vld_pipe[LAT]),
      .d         (rom_rd_data[k*ROM_RD_BW +: ROM_RD_BW]),
      .q         (ram_wr_data[k*ROM_RD_BW +: ROM_RD_BW])
    );
  end

endmodule
